// File: rtl/i2s_tx_serializer_pkg.sv
// Shared definitions for the I2S transmitter.
//   WS_LEFT / WS_RIGHT         : word-select levels for the two channels
//   DEF_DATA_W / DEF_SLOT_W /
//   DEF_CLK_DIV                : default geometry (24-bit samples, 32-bit slots, clk/4)
//   clog2()                    : counter width helper, never returns less than 1
package i2s_pkg;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  localparam int DEF_DATA_W  = 24;
  localparam int DEF_SLOT_W  = 32;
  localparam int DEF_CLK_DIV = 4;

  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/i2s_tx_serializer_if.sv
// Sample-pair stream into the I2S transmitter.
//   s_valid : source has a left/right pair on s_left/s_right
//   s_ready : sink holding register is empty
//   s_left  : left-channel sample
//   s_right : right-channel sample
// Handshake: a pair transfers on every rising clk edge where s_valid && s_ready.
// The source keeps s_valid and the data stable until that edge; s_ready does
// not depend on s_valid.
interface i2s_tx_serializer_if #(
  parameter int DATA_W = i2s_pkg::DEF_DATA_W
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_left;
  logic [DATA_W-1:0] s_right;

  modport master (output s_valid, output s_left, output s_right, input s_ready);
  modport slave  (input s_valid, input s_left, input s_right, output s_ready);

endinterface

// File: rtl/i2s_tx_serializer_clk_div.sv
// Bit-clock divider for the I2S transmitter.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   enable    : 1 = count; 0 = counter cleared, sclk low
//   sclk      : clk/CLK_DIV, high for the upper half of the count
//   fall_tick : 1-clk strobe where sd/ws may change (sclk falling edge, or the
//               first clk after enable rises)
module i2s_clk_div
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic sclk,
  output logic fall_tick
);

  localparam int DC_W = clog2(CLK_DIV);
  localparam int HALF = CLK_DIV / 2;

  logic [DC_W-1:0] dc;
  logic [DC_W-1:0] dc_next;
  logic            en_d;
  logic            dc_last;

  assign dc_last = (dc == DC_W'(CLK_DIV - 1));

  always_comb begin
    dc_next = dc_last ? '0 : dc + 1'b1;
  end

  // The first enabled clk counts as a falling edge so the first bit is driven
  // half a period before sclk first rises.
  assign fall_tick = enable && (!en_d || dc_last);

  // sclk is registered from dc_next so it is glitch-free and matches dc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dc   <= '0;
      en_d <= 1'b0;
      sclk <= 1'b0;
    end else if (!enable) begin
      dc   <= '0;
      en_d <= 1'b0;
      sclk <= 1'b0;
    end else begin
      dc   <= dc_next;
      en_d <= 1'b1;
      sclk <= (dc_next >= DC_W'(HALF));
    end
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// Stereo Philips-I2S transmitter (MSB-first, data one bit after ws edge).
//   clk, rst_n   : system clock, asynchronous active-low reset
//   enable       : 1 = run; 0 = lines idle, bit/divider counters cleared
//   s (slave)    : sample-pair stream into a one-entry holding register
//   underrun_clr : clears the sticky underrun flag
//   sclk, ws, sd : I2S pins; ws 0 = left, 1 = right
//   frame_start  : 1-clk pulse when a frame enters the shift register
//   underrun     : sticky, a frame load found the holding register empty
// Build option I2S_UNDERRUN_HOLD_EN: on underrun, resend the last loaded pair
// (zeros if none since reset); otherwise an all-zero frame is sent.
module i2s_tx_serializer
  import i2s_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SLOT_W  = DEF_SLOT_W,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  i2s_tx_serializer_if.slave  s,
  input  logic                underrun_clr,
  output logic                sclk,
  output logic                ws,
  output logic                sd,
  output logic                frame_start,
  output logic                underrun
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int BC_W    = clog2(FRAME_W);

  logic               fall_tick;
  logic [BC_W-1:0]    bc;
  logic               full;
  logic [DATA_W-1:0]  hold_l;
  logic [DATA_W-1:0]  hold_r;
  logic [FRAME_W-1:0] shift_q;
  logic               load;
  logic               accept;
  logic               ws_next;
  logic [DATA_W-1:0]  sub_l;
  logic [DATA_W-1:0]  sub_r;
  logic [FRAME_W-1:0] load_frame;

  i2s_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .sclk      (sclk),
    .fall_tick (fall_tick)
  );

  assign s.s_ready = !full;
  assign accept    = s.s_valid && !full;
  assign load      = fall_tick && (bc == '0);

`ifdef I2S_UNDERRUN_HOLD_EN
  logic [DATA_W-1:0] last_l;
  logic [DATA_W-1:0] last_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_l <= '0;
      last_r <= '0;
    end else if (load && full) begin
      last_l <= hold_l;
      last_r <= hold_r;
    end
  end

  assign sub_l = last_l;
  assign sub_r = last_r;
`else
  assign sub_l = '0;
  assign sub_r = '0;
`endif

  // Each sample sits left-justified in its slot; shifts avoid a zero-width
  // pad when DATA_W == SLOT_W.
  always_comb begin
    load_frame = '0;
    if (full) begin
      load_frame = (FRAME_W'(hold_l) << (FRAME_W - DATA_W))
                 | (FRAME_W'(hold_r) << (SLOT_W - DATA_W));
    end else begin
      load_frame = (FRAME_W'(sub_l) << (FRAME_W - DATA_W))
                 | (FRAME_W'(sub_r) << (SLOT_W - DATA_W));
    end
  end

  // ws switches one bit before each slot's MSB.
  always_comb begin
    ws_next = WS_LEFT;
    if (bc >= BC_W'(SLOT_W - 1) && bc <= BC_W'(FRAME_W - 2)) ws_next = WS_RIGHT;
  end

  // bc is the index of the bit driven at the next fall tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bc          <= '0;
      shift_q     <= '0;
      ws          <= 1'b0;
      sd          <= 1'b0;
      frame_start <= 1'b0;
    end else if (!enable) begin
      bc          <= '0;
      ws          <= 1'b0;
      sd          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= load;
      if (fall_tick) begin
        ws <= ws_next;
        bc <= (bc == BC_W'(FRAME_W - 1)) ? '0 : bc + 1'b1;
        if (load) begin
          sd      <= load_frame[FRAME_W-1];
          shift_q <= load_frame << 1;
        end else begin
          sd      <= shift_q[FRAME_W-1];
          shift_q <= shift_q << 1;
        end
      end
    end
  end

  // Holding register and sticky flag keep running while disabled. An accept
  // in the same clk as an underrun load fills the register for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      hold_l   <= '0;
      hold_r   <= '0;
      underrun <= 1'b0;
    end else begin
      if (accept) begin
        full   <= 1'b1;
        hold_l <= s.s_left;
        hold_r <= s.s_right;
      end else if (load && full) begin
        full <= 1'b0;
      end
      if (load && !full)     underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
    end
  end

endmodule
